// File: rtl/button_event_decoder.sv
// Per-key gesture classifier: short press, long press, double click and auto-repeat pulses.
// Build option: define BUTTON_REPEAT_EN to emit repeat_pulse periodically while long-held.
module button_event_decoder #(
  parameter int CNT_W      = 27,
  parameter int LONG_CNT   = 25_000_000,
  parameter int DCLICK_CNT = 7_500_000,
  parameter int REPEAT_CNT = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [2:0] debug_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    WAIT_2ND  = 3'd2,
    PRESSED2  = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  if (LONG_CNT < 2 || DCLICK_CNT < 2 || REPEAT_CNT < 2 ||
      longint'(LONG_CNT) >= (longint'(1) << CNT_W) ||
      longint'(DCLICK_CNT) >= (longint'(1) << CNT_W) ||
      longint'(REPEAT_CNT) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("button_event_decoder: timing constant out of range for CNT_W");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             prev;
  logic             fall, rise;
  logic             long_to, dclick_to;
  logic             short_next, long_next, double_next;

  // prev resets to "pressed" so a key held through reset produces no fall.
  assign fall      = prev & ~btn_level;
  assign rise      = ~prev & btn_level;
  assign long_to   = (cnt == CNT_W'(LONG_CNT - 1));
  assign dclick_to = (cnt == CNT_W'(DCLICK_CNT - 1));

`ifdef BUTTON_REPEAT_EN
  logic repeat_to;
  logic repeat_next;
  assign repeat_to = (cnt == CNT_W'(REPEAT_CNT - 1));
`endif

  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 1'b1;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
`ifdef BUTTON_REPEAT_EN
    repeat_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (fall) state_next = PRESSED;
      end
      PRESSED: begin
        // A release on the same cycle as the long timeout still counts as a release.
        if (rise) begin
          state_next = WAIT_2ND;
          cnt_next   = '0;
        end else if (long_to) begin
          state_next = LONG_HELD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end
      end
      WAIT_2ND: begin
        if (fall) begin
          state_next = PRESSED2;
          cnt_next   = '0;
        end else if (dclick_to) begin
          state_next = IDLE;
          cnt_next   = '0;
          short_next = 1'b1;
        end
      end
      PRESSED2: begin
        cnt_next = '0;
        if (rise) begin
          state_next  = IDLE;
          double_next = 1'b1;
        end
      end
      LONG_HELD: begin
        if (rise) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
`ifdef BUTTON_REPEAT_EN
          if (repeat_to) begin
            cnt_next    = '0;
            repeat_next = 1'b1;
          end
`else
          cnt_next = '0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      prev         <= btn_level;
      short_pulse  <= short_next;
      long_pulse   <= long_next;
      double_pulse <= double_next;
    end
  end

`ifdef BUTTON_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_pulse <= 1'b0;
    else        repeat_pulse <= repeat_next;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  assign busy        = (state != IDLE);
  assign debug_state = state;

endmodule
